// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier: retires one Booth digit per clock into a 2*WIDTH accumulator.
// Optional abort input enabled by defining MULT_ABORT_EN.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
`ifdef MULT_ABORT_EN
  input  logic                      abort,
`endif
  input  logic signed [WIDTH-1:0]   x,
  input  logic signed [WIDTH-1:0]   y,
  output logic                      busy,
  output logic                      done,
  output logic signed [2*WIDTH-1:0] product
);

  localparam int HALF  = WIDTH / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    r_state;
  logic [WIDTH:0]            r_xr;
  logic signed [WIDTH-1:0]   r_y;
  logic [2*WIDTH-1:0]        r_acc;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_busy;
  logic                      r_done;
  logic signed [2*WIDTH-1:0] r_product;

  logic [WIDTH+2:0]          w_pp_raw;
  logic                      w_neg;
  logic [WIDTH+1:0]          w_ppx;
  logic [2*WIDTH-1:0]        w_ext;
  logic [2*WIDTH-1:0]        w_addend;
  logic [2*WIDTH-1:0]        w_cin;
  logic [2*WIDTH-1:0]        w_acc_next;

  // Returns {negate, partial product already inverted when negating}; the +1 is applied as carry-in.
  function automatic logic [WIDTH+2:0] booth_pp(input logic [2:0] d,
                                                input logic signed [WIDTH-1:0] m);
    logic signed [WIDTH+1:0] m1;
    logic signed [WIDTH+1:0] m2;
    logic signed [WIDTH+1:0] sel;
    logic                    neg;
    m1  = {{2{m[WIDTH-1]}}, m};
    m2  = {m[WIDTH-1], m, 1'b0};
    sel = '0;
    neg = 1'b0;
    case (d)
      3'b001, 3'b010: sel = m1;
      3'b011:         sel = m2;
      3'b100:         begin sel = m2; neg = 1'b1; end
      3'b101, 3'b110: begin sel = m1; neg = 1'b1; end
      default:        sel = '0;
    endcase
    return {neg, neg ? ~sel : sel};
  endfunction

  // Digit decode and shifted add; the inverted PP shifts in zeros, so carry-in sits at bit 2*cnt.
  always_comb begin
    w_pp_raw   = booth_pp(r_xr[2:0], r_y);
    w_neg      = w_pp_raw[WIDTH+2];
    w_ppx      = w_pp_raw[WIDTH+1:0];
    w_ext      = {{(WIDTH-2){w_ppx[WIDTH+1]}}, w_ppx};
    w_addend   = w_ext << {r_cnt, 1'b0};
    w_cin      = (2*WIDTH)'(w_neg) << {r_cnt, 1'b0};
    w_acc_next = r_acc + w_addend + w_cin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_xr      <= '0;
      r_y       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
`ifdef MULT_ABORT_EN
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else
`endif
          begin
            r_acc <= w_acc_next;
            r_xr  <= $signed(r_xr) >>> 2;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST) begin
              r_product <= $signed(w_acc_next);
              r_state   <= S_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end
        default: begin
          r_done <= 1'b0;
          if (start) begin
            r_xr    <= {x, 1'b0};
            r_y     <= y;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq (WIDTH=8): checks handshake timing and signed products.
module tb_booth_mult_seq;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [7:0]  x;
  logic signed [7:0]  y;
  logic               busy;
  logic               done;
  logic signed [15:0] product;
`ifdef MULT_ABORT_EN
  logic               abort;
`endif

  int          n_tot = 0;
  int          n_bad = 0;
  int          n_done = 0;
  int          n_exp_done = 0;
  logic [15:0] q_exp[$];
  logic [15:0] last_prod;

  booth_mult_seq #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
`ifdef MULT_ABORT_EN
    .abort   (abort),
`endif
    .x       (x),
    .y       (y),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (q_exp.size() == 0) chk("spurious_done", 16'd1, 16'd0);
      else chk("product", product, q_exp.pop_front());
    end
    if (busy && done) chk("busy_done_excl", 16'd1, 16'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op, check busy for 4 cycles with product held, then done in cycle 5.
  task automatic do_op(input logic signed [7:0] a, input logic signed [7:0] b,
                       input logic [15:0] exp, input bit pulse_mid);
    x = a;
    y = b;
    start = 1'b1;
    q_exp.push_back(exp);
    n_exp_done++;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("busy_run", {15'd0, busy}, 16'd1);
      chk("done_run", {15'd0, done}, 16'd0);
      chk("prod_hold_run", product, last_prod);
      if (pulse_mid && i == 2) begin
        start = 1'b1;
        x = 8'sd100;
        y = 8'sd100;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("done_pulse", {15'd0, done}, 16'd1);
    chk("busy_at_done", {15'd0, busy}, 16'd0);
    chk("prod_at_done", product, exp);
    last_prod = exp;
  endtask

  initial begin
    logic signed [7:0] ra;
    logic signed [7:0] rb;
    logic signed [15:0] rp;
    rst = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
`ifdef MULT_ABORT_EN
    abort = 1'b0;
`endif
    last_prod = 16'h0000;
    tick();
    tick();
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_prod", product, 16'h0000);
    rst = 1'b0;
    tick();

    do_op(8'sd3, 8'sd5, 16'h000F, 1'b0);
    tick();
    chk("idle_done", {15'd0, done}, 16'd0);
    chk("idle_hold", product, 16'h000F);

    do_op(-8'sd128, -8'sd128, 16'h4000, 1'b0);
    tick();
    do_op(8'sd127, -8'sd128, 16'hC080, 1'b0);
    tick();
    do_op(-8'sd1, -8'sd1, 16'h0001, 1'b1);
    do_op(-8'sd7, 8'sd9, 16'hFFC1, 1'b0);
    tick();

    x = 8'sd50;
    y = 8'sd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_prod = 16'h0000;
    chk("midrst_busy", {15'd0, busy}, 16'd0);
    chk("midrst_done", {15'd0, done}, 16'd0);
    chk("midrst_prod", product, 16'h0000);
    for (int i = 0; i < 6; i++) tick();
    do_op(-8'sd6, -8'sd6, 16'h0024, 1'b0);
    tick();

    do_op(8'sd0, -8'sd77, 16'h0000, 1'b0);
    do_op(-8'sd128, 8'sd127, 16'hC080, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rp = 16'(ra) * 16'(rb);
      do_op(ra, rb, rp, 1'b0);
      if (i % 2 == 0) tick();
    end
    tick();

`ifdef MULT_ABORT_EN
    do_op(8'sd3, 8'sd5, 16'h000F, 1'b0);
    tick();
    x = 8'sd10;
    y = 8'sd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_done", {15'd0, done}, 16'd0);
    chk("abort_prod", product, 16'h000F);
    for (int i = 0; i < 6; i++) tick();
`endif

    for (int i = 0; i < 3; i++) tick();
    chk("done_count", 16'(n_done), 16'(n_exp_done));
    chk("queue_empty", 16'(q_exp.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
